// File: rtl/unsigned_16by8_div_seq.sv
// Sequential unsigned restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, valid/ready handshake on both sides.
module unsigned_16by8_div_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 div_by_zero,
    output logic                 overflow
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   qout_q, qout_d;
    logic [WIDTH-1:0]   rout_q, rout_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     step_rem;
    logic [WIDTH-1:0]   step_quo;
    logic               qbit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            shift_q <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            qout_q  <= '0;
            rout_q  <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            shift_q <= shift_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            qout_q  <= qout_d;
            rout_q  <= rout_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    // Compare/subtract is done at WIDTH+1 bits so the shifted-in trial never truncates.
    always_comb begin
        trial    = {rem_q[WIDTH-1:0], shift_q[WIDTH-1]};
        qbit     = (trial >= {1'b0, dvs_q});
        step_rem = qbit ? (trial - {1'b0, dvs_q}) : trial;
        step_quo = {quo_q[WIDTH-2:0], qbit};
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        shift_d = shift_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        qout_d  = qout_q;
        rout_d  = rout_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvs_d = divisor;
                    if (divisor == '0) begin
                        state_d = DONE;
                        qout_d  = '1;
                        rout_d  = dividend[WIDTH-1:0];
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                    end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                        state_d = DONE;
                        qout_d  = '1;
                        rout_d  = '1;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        rem_d   = {1'b0, dividend[2*WIDTH-1:WIDTH]};
                        shift_d = dividend[WIDTH-1:0];
                        quo_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    qout_d  = step_quo;
                    rout_d  = step_rem[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = qout_q;
    assign remainder   = rout_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_unsigned_16by8_div_seq.sv
// Directed and randomised checks of the sequential 16/8 divider against hand values and a / % model.
module tb_unsigned_16by8_div_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    unsigned_16by8_div_seq #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction: accept, wait for result, stall, then hand-shake it away.
    task automatic run_op(input logic [15:0] dd, input logic [7:0] dv,
                          input logic [7:0] exp_q, input logic [7:0] exp_r,
                          input logic exp_dbz, input logic exp_ovf,
                          input int stall, input logic ready_early);
        int lat;
        int exp_lat;
        exp_lat = (exp_dbz || exp_ovf) ? 0 : 8;
        @(negedge clk);
        check_eq("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        dividend  = dd;
        divisor   = dv;
        out_ready = ready_early;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        out_ready = 1'b0;
        check_eq("latency", lat, exp_lat);
        check_eq("quotient", quotient, exp_q);
        check_eq("remainder", remainder, exp_r);
        check_eq("div_by_zero", div_by_zero, exp_dbz);
        check_eq("overflow", overflow, exp_ovf);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            dividend = 16'h0101;
            divisor  = 8'h03;
            @(posedge clk);
            #1;
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_in_ready", in_ready, 0);
            check_eq("stall_q", quotient, exp_q);
            check_eq("stall_r", remainder, exp_r);
            check_eq("stall_flags", {div_by_zero, overflow}, {exp_dbz, exp_ovf});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("post_valid", out_valid, 0);
        check_eq("post_in_ready", in_ready, 1);
        check_eq("hold_q", quotient, exp_q);
        check_eq("hold_r", remainder, exp_r);
    endtask

    task automatic run_model(input logic [15:0] dd, input logic [7:0] dv, input int stall);
        int unsigned q;
        int unsigned r;
        if (dv == 8'h00) begin
            run_op(dd, dv, 8'hFF, dd[7:0], 1'b1, 1'b0, stall, 1'b0);
        end else begin
            q = int'(dd) / int'(dv);
            r = int'(dd) % int'(dv);
            if (q > 255) run_op(dd, dv, 8'hFF, 8'hFF, 1'b0, 1'b1, stall, 1'b0);
            else         run_op(dd, dv, q[7:0], r[7:0], 1'b0, 1'b0, stall, $urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        logic [15:0] rd;
        logic [7:0]  rv;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_q", quotient, 0);
        check_eq("rst_r", remainder, 0);
        check_eq("rst_flags", {div_by_zero, overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 8'h56, 8'h36, 8'h10, 1'b0, 1'b0, 0, 1'b1);
        run_op(16'hFE01, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1, 1'b0);
        run_op(16'h00AB, 8'h00, 8'hFF, 8'hAB, 1'b1, 1'b0, 0, 1'b0);
        run_op(16'h1200, 8'h12, 8'hFF, 8'hFF, 1'b0, 1'b1, 0, 1'b0);
        run_op(16'h0FFF, 8'h10, 8'hFF, 8'h0F, 1'b0, 1'b0, 5, 1'b0);
        run_op(16'h0000, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0);

        // Reset during the fourth restoring step.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 16'h1234;
        divisor  = 8'h56;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_q", quotient, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 0, 1'b0);

        for (int k = 0; k < 300; k++) begin
            rd = 16'($urandom);
            rv = 8'($urandom);
            if (k % 4 == 0) rd[15:8] = rd[15:8] % 8'h20;
            if (k % 37 == 0) rv = 8'h00;
            run_model(rd, rv, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
